// File: rtl/mux_pkg.sv
// Shared definitions for the mux/dmux family: default width, source codes
// and the round-robin search helper.
package mux_pkg;

    localparam int MUX_WIDTH = 16;

    // Source codes; identical to the dmux sel encoding so out_sel can steer a dmux.
    localparam logic [1:0] SEL_CH0  = 2'b00;
    localparam logic [1:0] SEL_CH1  = 2'b01;
    localparam logic [1:0] SEL_CH2  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam logic [1:0] PTR_RST  = SEL_CH2;   // ch0 searched first after reset

    // Channel visited k steps after p in the cyclic order 0,1,2.
    function automatic logic [1:0] rr_idx(input logic [1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        s = s % 3;
        return s[1:0];
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter, purely combinational. The channel just after
// ptr has top priority; ptr itself is considered last.
module rr_arb3
    import mux_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    input  logic       en,
    output logic [2:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       any
);

    // Walk ptr+1, ptr+2, ptr and stop at the first requester.
    always_comb begin
        logic [1:0] idx;
        gnt     = 3'b000;
        gnt_idx = SEL_CH0;
        any     = 1'b0;
        idx     = SEL_CH0;
        if (en) begin
            for (int unsigned k = 1; k <= 3; k++) begin
                idx = rr_idx(ptr, k);
                if (!any && req[idx]) begin
                    any     = 1'b1;
                    gnt_idx = idx;
                    gnt     = 3'b001 << idx;
                end
            end
        end
    end

endmodule

// File: rtl/mux_rr3.sv
// Registered 3-to-1 merge stage. Round-robin selects one producer, its word is
// captured in a single output slot tagged with the dmux-compatible source code.
module mux_rr3
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       in_valid,
    output logic [2:0]       in_ready,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             load;
    logic             en;
    logic [1:0]       ptr;
    logic [2:0]       gnt;
    logic [1:0]       gnt_idx;
    logic             any;
    logic [WIDTH-1:0] win_data;

    // Slot is free or draining; reset suppresses all grants.
    assign load = !out_valid || out_ready;
    assign en   = load && !rst;

    rr_arb3 u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .en      (en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign in_ready = gnt;

    // Select the winning channel's word.
    always_comb begin
        case (gnt_idx)
            SEL_CH1: win_data = in1;
            SEL_CH2: win_data = in2;
            default: win_data = in0;
        endcase
    end

    // Output slot and rr pointer: load on grant, empty on drain without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_sel   <= SEL_CH0;
            out_valid <= 1'b0;
            ptr       <= PTR_RST;
        end else if (load) begin
            if (any) begin
                out       <= win_data;
                out_sel   <= gnt_idx;
                out_valid <= 1'b1;
                ptr       <= gnt_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr3.sv
// Bench for mux_rr3: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural model and a
// dmux-steered per-channel scoreboard.
module tb_mux_rr3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in0, in1, in2;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [15:0] out;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    // model state: slot contents and last granted channel
    bit          mvalid = 1'b0;
    logic [15:0] mout   = '0;
    int          msel   = 0;
    int          mptr   = 2;
    logic [15:0] q [3][$];

    mux_rr3 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] word(input int c);
        return (c == 0) ? in0 : (c == 1) ? in1 : in2;
    endfunction

    // first valid channel in cyclic order after the last grant, or -1
    function automatic int pick(input logic [2:0] v, input int p);
        for (int off = 1; off <= 3; off++) begin
            int c;
            c = (p + off) % 3;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Per-cycle compare and model advance (inputs are stable from posedge+1).
    always @(negedge clk) begin
        int          w;
        logic [2:0]  exp_rdy;
        logic [15:0] e;
        bit          ld;
        ld = !rst && (!mvalid || out_ready);
        w  = ld ? pick(in_valid, mptr) : -1;
        exp_rdy = (w >= 0) ? (3'b001 << w) : 3'b000;
        chk("in_ready", {29'd0, in_ready}, {29'd0, exp_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, mvalid});
        chk("out", {16'd0, out}, {16'd0, mout});
        chk("out_sel", {30'd0, out_sel}, msel);
        chk("ready_onehot0", {31'd0, $onehot0(in_ready)}, 32'd1);
        chk("sel_not_11", {31'd0, (out_sel != 2'b11)}, 32'd1);
        // downstream dmux: word goes to output index out_sel
        if (!rst && out_valid && out_ready && out_sel != 2'b11) begin
            if (q[out_sel].size() == 0) begin
                checks++; errors++;
                $display("FAIL dmux_dup ch%0d got %h expected none", out_sel, out);
            end else begin
                e = q[out_sel].pop_front();
                chk("dmux_stream", {16'd0, out}, {16'd0, e});
            end
        end
        // next state
        if (rst) begin
            mvalid = 1'b0; mout = '0; msel = 0; mptr = 2;
            for (int c = 0; c < 3; c++) q[c].delete();
        end else if (ld) begin
            if (w >= 0) begin
                q[w].push_back(word(w));
                mvalid = 1'b1; mout = word(w); msel = w; mptr = w;
            end else begin
                mvalid = 1'b0;
            end
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in0 = '0; in1 = '0; in2 = '0; in_valid = 3'b000; out_ready = 1'b0;
        nxt(); nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {16'd0, out}, 32'd0);
        nxt();

        // 1: single request from ch0
        in0 = 16'hFFFF; in_valid = 3'b001; out_ready = 1'b1;
        @(negedge clk); chk("t1_ready", {29'd0, in_ready}, 32'b001);
        nxt(); in_valid = 3'b000;
        @(negedge clk);
        chk("t1_out", {16'd0, out}, 32'hFFFF);
        chk("t1_sel", {30'd0, out_sel}, 32'd0);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);

        // 2: all valid, strict rotation from ch0
        nxt(); rst = 1'b1; nxt(); rst = 1'b0;
        in0 = 16'h0001; in1 = 16'h0002; in2 = 16'h0003; in_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            nxt(); @(negedge clk);
            chk("t2_sel", {30'd0, out_sel}, k % 3);
            chk("t2_out", {16'd0, out}, (k % 3) + 1);
            chk("t2_valid", {31'd0, out_valid}, 32'd1);
        end

        // 3: backpressure holding 0002 from ch1
        nxt(); in_valid = 3'b010;
        nxt(); in_valid = 3'b111; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_ready", {29'd0, in_ready}, 32'd0);
            chk("t3_out", {16'd0, out}, 32'h0002);
            chk("t3_sel", {30'd0, out_sel}, 32'd1);
            nxt();
        end
        out_ready = 1'b1;
        @(negedge clk); chk("t3_regrant", {29'd0, in_ready}, 32'b100);
        nxt(); @(negedge clk); chk("t3_sel_ch2", {30'd0, out_sel}, 32'd2);

        // 4: lone requester ch1
        nxt(); in1 = 16'hABCD; in_valid = 3'b010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_ready", {29'd0, in_ready}, 32'b010);
            if (k > 0) chk("t4_sel", {30'd0, out_sel}, 32'd1);
            nxt();
        end
        in_valid = 3'b000;
        @(negedge clk);
        chk("t4_last_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_last_out", {16'd0, out}, 32'hABCD);
        nxt(); @(negedge clk);
        chk("t4_drained", {31'd0, out_valid}, 32'd0);
        chk("t4_hold_out", {16'd0, out}, 32'hABCD);
        chk("t4_hold_sel", {30'd0, out_sel}, 32'd1);

        // 5: reset while holding a ch2 word
        nxt(); in_valid = 3'b100; out_ready = 1'b0;
        nxt(); in_valid = 3'b111; rst = 1'b1;
        @(negedge clk);
        chk("t5_full_sel", {30'd0, out_sel}, 32'd2);
        chk("t5_rst_ready", {29'd0, in_ready}, 32'd0);
        nxt(); rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_first", {29'd0, in_ready}, 32'b001);
        nxt(); @(negedge clk);
        chk("t5_sel", {30'd0, out_sel}, 32'd0);

        // 6: random traffic
        for (int n = 0; n < 3000; n++) begin
            nxt();
            rst       = ($urandom_range(0, 199) == 0);
            in0       = 16'($urandom);
            in1       = 16'($urandom);
            in2       = 16'($urandom);
            in_valid  = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        nxt(); rst = 1'b0; in_valid = 3'b000; out_ready = 1'b1;
        nxt(); nxt();
        @(negedge clk);
        chk("sb_leftover", q[0].size() + q[1].size() + q[2].size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr3.md
Name: mux_rr3

Overview:
- Registered 3-to-1 merge stage: the counterpart of the 1-to-3 demultiplexer (dmux).
- Three 16-bit producer channels compete with valid/ready handshakes; a round-robin arbiter picks one winner.
- The winner's word is forwarded through a single output register, tagged with a 2-bit source code.
- The source code uses the same encoding as the dmux sel input, so mux_rr3 output can drive a dmux directly. A downstream dmux steered by out_sel returns each word to the output index matching its input index.

Parameters:
WIDTH, 16, data width of every channel and of the output.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
in0  input  WIDTH  channel 0 data
in1  input  WIDTH  channel 1 data
in2  input  WIDTH  channel 2 data
in_valid  input  3  bit i: channel i offers a word
in_ready  output  3  bit i: channel i word accepted this cycle (one-hot or zero)
out  output  WIDTH  registered output data
out_sel  output  2  source of out: 00=ch0, 01=ch1, 10=ch2; 11 never driven
out_valid  output  1  out/out_sel hold a word
out_ready  input  1  consumer accepts the word this cycle

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. Nothing is sampled or reset asynchronously.
- Reset values: out_valid=0, out=0, out_sel=2'b00, rr pointer ptr=2'b10, so ch0 has first priority after reset.
- in_ready is 0 during any cycle with rst=1.
- State: a single output slot, EMPTY (out_valid=0) or FULL (out_valid=1), plus ptr (last granted channel, 0..2).
- load = !out_valid | out_ready. This is the slot being free or draining this cycle.
- Arbitration (combinational, only when load=1):
  - Search order starts at ptr+1 mod 3, then ptr+2 mod 3, then ptr.
  - The first channel with in_valid set is the winner; in_ready is one-hot on the winner.
  - With no valid channel, in_ready=000.
- When load=0 (FULL and out_ready=0): in_ready=000, and out, out_sel, out_valid hold exactly.
- Transfer from channel i occurs on in_valid[i] & in_ready[i]. On the next edge:
  - out<=in_i, out_sel<=i, out_valid<=1, ptr<=i.
- Drain with no refill (load=1, no winner): out_valid<=0 next edge; out and out_sel hold their last values; ptr unchanged.
- Simultaneous drain and refill (FULL, out_ready=1, winner present): the old word leaves and the new one is loaded on the same edge. Throughput is 1 word/cycle, with no bubble.
- Latency: 1 cycle from accepted input to out_valid.
- A single requesting channel is granted every cycle regardless of ptr.
- Fairness: with all three valid continuously and out_ready=1, grants are strictly ch0,ch1,ch2,ch0...
  - No channel waits more than 2 grants once it asserts valid.
- out_ready while EMPTY is ignored, with no side effects.
- in_valid may drop without a transfer; the block keeps no memory of requests.
- Reset mid-operation: a held word is discarded and out_valid=0 on the cycle after rst is sampled high. ptr returns to 2'b10.
- out_sel=2'b11 is unreachable; verification asserts this.

Decomposition:
- Shared package mux_pkg:
  - WIDTH default.
  - Source codes SEL_CH0=2'b00, SEL_CH1=2'b01, SEL_CH2=2'b10, SEL_NONE=2'b11.
  - This package is shared with dmux/dmuxif benches.
- One sub-module, rr_arb3:
  - Purely combinational.
  - Inputs: req[2:0], ptr[1:0], en.
  - Outputs: gnt[2:0] one-hot, gnt_idx[1:0], any.
- The top level holds the output register and ptr.

Test Plan:
1. Reset, then in0=16'hFFFF, in_valid=001, out_ready=1 -> in_ready=001 that cycle; next cycle out=FFFF, out_sel=00, out_valid=1.
2. All valid (in0=0001, in1=0002, in2=0003), out_ready=1 for 6 cycles -> out_sel sequence 00,01,10,00,01,10, out sequence 0001,0002,0003 repeated, out_valid never drops.
3. Backpressure: FULL with out=0002/out_sel=01, out_ready=0 for 4 cycles while all valid -> in_ready=000, out stable; on out_ready=1, next grant is ch2 (out_sel=10).
4. Only ch1 valid (in1=ABCD) for 3 cycles, out_ready=1 -> grants 010 each cycle, out_sel=01 each cycle; then in_valid=000 -> out_valid=0 one cycle later, out holds ABCD.
5. Mid-operation reset: FULL with out_sel=10, assert rst for 1 cycle with all valid -> in_ready=000 during rst, out_valid=0 after; first post-reset grant is ch0.
6. Coverage/assertions over random stimulus:
   - in_ready is always one-hot or zero.
   - out_sel is never 11.
   - No word is lost or duplicated; the scoreboard runs this block's output into a dmux steered by out_sel and compares each dmux output against its channel's input stream.
